// File: rtl/alu_seq_responder_if.sv
// alu_seq_responder_if: request/response channel bundle for the sequential ALU
//   master drives in_valid, A, B, opcode, out_ready
//   slave  drives in_ready, out_valid, result (2W), err, ovf
interface alu_seq_responder_if #(parameter int W = 4);
    logic           in_valid;
    logic           in_ready;
    logic [W-1:0]   A;
    logic [W-1:0]   B;
    logic [2:0]     opcode;
    logic           out_valid;
    logic           out_ready;
    logic [2*W-1:0] result;
    logic           err;
    logic           ovf;
    modport master (
        output in_valid, A, B, opcode, out_ready,
        input  in_ready, out_valid, result, err, ovf
    );
    modport slave (
        input  in_valid, A, B, opcode, out_ready,
        output in_ready, out_valid, result, err, ovf
    );
endinterface

// File: rtl/alu_seq_responder.sv
// alu_seq_responder: handshaked multi-cycle W-bit ALU (iterative DIV/MOD/POW)
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of alu_seq_responder_if (request in, response out)
module alu_seq_responder #(parameter int W = 4) (
    input logic                clk,
    input logic                rst_n,
    alu_seq_responder_if.slave bus
);
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_MUL = 3'b010;
    localparam logic [2:0] OP_DIV = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_MOD = 3'b110;
    localparam logic [W-1:0] W_CNT = W'(W);
    state_t         state_q, state_d;
    logic [W-1:0]   a_q, a_d, b_q, b_d, cnt_q, cnt_d, quo_q, quo_d, rem_q, rem_d;
    logic [2:0]     op_q, op_d;
    logic [2*W-1:0] acc_q, acc_d, result_q, result_d;
    logic           err_q, err_d, ovf_q, ovf_d;
    logic           is_div, div_zero, ge, pow_ovf;
    logic [W-1:0]   n_iter, diff;
    logic [W:0]     sh, sum;
    logic [3*W-1:0] prod;
    logic [2*W-1:0] calc;
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        acc_d    = acc_q;
        result_d = result_q;
        err_d    = err_q;
        ovf_d    = ovf_q;
        is_div   = op_q == OP_DIV || op_q == OP_MOD;
        div_zero = is_div && b_q == '0;
        // Iteration count: POW runs B cycles, non-zero DIV/MOD one per quotient bit.
        n_iter   = op_q == 3'b111 ? b_q : (is_div && !div_zero) ? W_CNT : '0;
        // Restoring division: shift next dividend bit into the partial remainder.
        sh       = {rem_q, quo_q[W-1]};
        ge       = sh >= {1'b0, b_q};
        prod     = {{2*W{1'b0}}, a_q} * {{W{1'b0}}, acc_q};
        pow_ovf  = |prod[3*W-1:2*W];
        sum      = {1'b0, a_q} + {1'b0, b_q};
        diff     = a_q >= b_q ? a_q - b_q : b_q - a_q;
        calc     = op_q == OP_ADD ? {{W-1{1'b0}}, sum} :
                   op_q == OP_SUB ? {{W{1'b0}}, diff} :
                   op_q == OP_MUL ? {{W{1'b0}}, a_q} * {{W{1'b0}}, b_q} :
                   op_q == OP_AND ? {{W{1'b0}}, a_q & b_q} :
                   op_q == OP_OR  ? {{W{1'b0}}, a_q | b_q} :
                   div_zero       ? '1 :
                   op_q == OP_DIV ? {{W{1'b0}}, quo_q} :
                   op_q == OP_MOD ? {{W{1'b0}}, rem_q} : acc_q;
        case (state_q)
            IDLE: if (bus.in_valid) begin
                state_d = BUSY;
                a_d     = bus.A;
                b_d     = bus.B;
                op_d    = bus.opcode;
                cnt_d   = '0;
                quo_d   = bus.A;
                rem_d   = '0;
                acc_d   = {{2*W-1{1'b0}}, 1'b1};
                err_d   = 1'b0;
                ovf_d   = 1'b0;
            end
            BUSY: if (cnt_q == n_iter) begin
                state_d  = DONE;
                result_d = calc;
                err_d    = div_zero;
            end else begin
                cnt_d = cnt_q + 1'b1;
                quo_d = {quo_q[W-2:0], ge};
                rem_d = ge ? W'(sh - {1'b0, b_q}) : sh[W-1:0];
                // Saturate and flag on overflow; keep iterating so latency stays B.
                if (op_q == 3'b111) begin
                    acc_d = pow_ovf ? '1 : prod[2*W-1:0];
                    ovf_d = ovf_q | pow_ovf;
                end
            end
            DONE: if (bus.out_ready) begin
                state_d  = IDLE;
                result_d = '0;
                err_d    = 1'b0;
                ovf_d    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= '0;
            cnt_q    <= '0;
            quo_q    <= '0;
            rem_q    <= '0;
            acc_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
        end
    end
    assign bus.in_ready  = state_q == IDLE;
    assign bus.out_valid = state_q == DONE;
    assign bus.result    = result_q;
    assign bus.err       = err_q;
    assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_alu_seq_responder.sv
// tb_alu_seq_responder: vector table, random model check and handshake/reset sequences
module tb_alu_seq_responder;
    logic clk, rst_n;
    int   n_chk = 0, n_err = 0;
    alu_seq_responder_if #(.W(4)) bus();
    alu_seq_responder #(.W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    initial clk = 1'b0;
    always #5 clk = ~clk;
    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [2:0] op;
        logic [7:0] res;
        logic       err;
        logic       ovf;
        int         lat;
    } vec_t;
    vec_t vecs[12];
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    // Reference: plain arithmetic on the operation's definition.
    function automatic void model(input logic [3:0] a, b, input logic [2:0] op,
                                  output logic [7:0] r, output logic e, o, output int lat);
        int acc;
        e = 1'b0; o = 1'b0; lat = 1; r = 8'd0;
        case (op)
            3'd0: r = 8'(int'(a) + int'(b));
            3'd1: r = 8'(a > b ? int'(a) - int'(b) : int'(b) - int'(a));
            3'd2: r = 8'(int'(a) * int'(b));
            3'd4: r = {4'd0, a & b};
            3'd5: r = {4'd0, a | b};
            3'd3, 3'd6: if (b == 0) begin
                r = 8'hFF; e = 1'b1;
            end else begin
                r = 8'(op == 3'd3 ? int'(a) / int'(b) : int'(a) % int'(b));
                lat = 5;
            end
            default: begin
                acc = 1;
                for (int i = 0; i < int'(b); i++) begin
                    acc = acc * int'(a);
                    if (acc > 255) begin acc = 255; o = 1'b1; end
                end
                r = 8'(acc); lat = 1 + int'(b);
            end
        endcase
    endfunction
    task automatic do_op(input logic [3:0] a, b, input logic [2:0] op,
                         output logic [7:0] r, output logic e, o, output int lat);
        int w = 0;
        while (!bus.in_ready && w < 100) begin tick(); w++; end
        bus.A = a; bus.B = b; bus.opcode = op; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        bus.in_valid = 1'b0; bus.A = ~a; bus.B = ~b;
        lat = 0;
        do begin tick(); lat++; end while (!bus.out_valid && lat < 40);
        r = bus.result; e = bus.err; o = bus.ovf;
        tick();
    endtask
    task automatic run_check(input string tag, input logic [3:0] a, b, input logic [2:0] op,
                             input logic [7:0] er, input logic ee, eo, input int el);
        logic [7:0] r; logic e, o; int lat;
        do_op(a, b, op, r, e, o, lat);
        chk({tag, "_result"}, 32'(r), 32'(er));
        chk({tag, "_err"}, 32'(e), 32'(ee));
        chk({tag, "_ovf"}, 32'(o), 32'(eo));
        chk({tag, "_lat"}, 32'(lat), 32'(el));
    endtask
    initial begin
        logic [3:0] ra, rb; logic [2:0] rop; logic [7:0] mr; logic me, mo; int ml;
        bit seen;
        vecs[0]  = '{4'd3,  4'd1,  3'd0, 8'd4,   1'b0, 1'b0, 1};
        vecs[1]  = '{4'd2,  4'd3,  3'd1, 8'd1,   1'b0, 1'b0, 1};
        vecs[2]  = '{4'd5,  4'd10, 3'd2, 8'd50,  1'b0, 1'b0, 1};
        vecs[3]  = '{4'd2,  4'd3,  3'd4, 8'd2,   1'b0, 1'b0, 1};
        vecs[4]  = '{4'd3,  4'd10, 3'd5, 8'd11,  1'b0, 1'b0, 1};
        vecs[5]  = '{4'd10, 4'd5,  3'd3, 8'd2,   1'b0, 1'b0, 5};
        vecs[6]  = '{4'd12, 4'd5,  3'd6, 8'd2,   1'b0, 1'b0, 5};
        vecs[7]  = '{4'd7,  4'd0,  3'd3, 8'hFF,  1'b1, 1'b0, 1};
        vecs[8]  = '{4'd3,  4'd2,  3'd7, 8'd9,   1'b0, 1'b0, 3};
        vecs[9]  = '{4'd0,  4'd0,  3'd7, 8'd1,   1'b0, 1'b0, 1};
        vecs[10] = '{4'd15, 4'd15, 3'd7, 8'hFF,  1'b0, 1'b1, 16};
        vecs[11] = '{4'd15, 4'd15, 3'd0, 8'd30,  1'b0, 1'b0, 1};
        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.A = '0; bus.B = '0; bus.opcode = '0;
        tick(); tick();
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_result", 32'(bus.result), 32'd0);
        chk("rst_err", 32'(bus.err), 32'd0);
        chk("rst_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 12; i++)
            run_check($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].op,
                      vecs[i].res, vecs[i].err, vecs[i].ovf, vecs[i].lat);
        for (int i = 0; i < 60; i++) begin
            ra = 4'($urandom); rb = 4'($urandom); rop = 3'($urandom);
            if (i % 10 == 0) rb = 4'd0;
            model(ra, rb, rop, mr, me, mo, ml);
            run_check($sformatf("rnd%0d_op%0d_%0d_%0d", i, rop, ra, rb), ra, rb, rop, mr, me, mo, ml);
        end
        bus.A = 4'd4; bus.B = 4'd5; bus.opcode = 3'd0; bus.in_valid = 1'b1; bus.out_ready = 1'b0;
        tick();
        bus.A = 4'd7; bus.B = 4'd2; bus.opcode = 3'd2;
        tick();
        chk("bp_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_result", 32'(bus.result), 32'd9);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk($sformatf("bp_hold_valid%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_hold_result%0d", i), 32'(bus.result), 32'd9);
            chk($sformatf("bp_hold_in_ready%0d", i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        tick();
        chk("bp_idle_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_idle_out_valid", 32'(bus.out_valid), 32'd0);
        tick();
        chk("bp_next_accepted", 32'(bus.in_ready), 32'd0);
        bus.in_valid = 1'b0;
        tick();
        chk("bp_next_valid", 32'(bus.out_valid), 32'd1);
        chk("bp_next_result", 32'(bus.result), 32'd14);
        tick();
        bus.A = 4'd10; bus.B = 4'd5; bus.opcode = 3'd3; bus.in_valid = 1'b1;
        tick();
        bus.in_valid = 1'b0;
        tick(); tick();
        chk("abort_busy", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
        chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.out_valid) seen = 1'b1;
        end
        chk("abort_no_response", 32'(seen), 32'd0);
        run_check("post_abort_add", 4'd1, 4'd1, 3'd0, 8'd2, 1'b0, 1'b0, 1);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
